// File: rtl/nn_accel.sv
// nn_accel: streaming fixed-point dot-product accelerator driven by the CPU enable/start handshake.
// Define NN_ACCEL_RELU_EN to write negative saturated results as zero.
module nn_accel #(
  parameter int          N_IN   = 16,
  parameter logic [15:0] X_BASE = 16'h0040,
  parameter logic [15:0] W_BASE = 16'h0080,
  parameter logic [15:0] Y_ADDR = 16'h00C0,
  parameter int          FRAC   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iACC_en,
  input  logic        iACC_start,
  output logic        oACC_done,
  output logic        oMemReq,
  output logic [15:0] oMemAddr,
  output logic        oMemRead,
  input  logic [15:0] iMemData,
  output logic        oMemWrite,
  output logic [15:0] oMemWData
);
  typedef enum logic [2:0] {IDLE, FETCH_X, FETCH_W, MAC, WRITE, DONE} state_t;
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic signed [15:0] x, x_nxt;
  logic signed [31:0] prod;
  logic signed [39:0] acc, acc_nxt, shifted;
  logic [15:0] result, wval, addr_nxt, wdata_nxt;
  logic prev_start, start_ev, last;
  logic done_nxt, req_nxt, rd_nxt, wr_nxt;
  assign start_ev = iACC_en & iACC_start & ~prev_start;
  assign last     = idx == IW'(N_IN - 1);
  assign prod     = x * $signed(iMemData);
  // Output registers load from next-state values, so wdata must see the freshly updated sum.
  assign shifted  = acc_nxt >>> FRAC;
  assign result   = shifted > 40'sd32767 ? 16'h7FFF :
                    shifted < -40'sd32768 ? 16'h8000 : shifted[15:0];
`ifdef NN_ACCEL_RELU_EN
  assign wval = result[15] ? 16'h0000 : result;
`else
  assign wval = result;
`endif
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    x_nxt     = x;
    acc_nxt   = acc;
    case (state)
      IDLE, DONE: if (start_ev) begin
        state_nxt = FETCH_X;
        idx_nxt   = '0;
        acc_nxt   = '0;
      end
      FETCH_X: state_nxt = FETCH_W;
      FETCH_W: begin
        state_nxt = MAC;
        x_nxt     = iMemData;
      end
      MAC: begin
        acc_nxt   = acc + 40'(prod);
        state_nxt = last ? WRITE : FETCH_X;
        idx_nxt   = last ? idx : idx + 1'b1;
      end
      WRITE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (!iACC_en && state != IDLE) state_nxt = IDLE;
  end
  always_comb begin
    req_nxt   = state_nxt inside {FETCH_X, FETCH_W, MAC, WRITE};
    rd_nxt    = state_nxt == FETCH_X || state_nxt == FETCH_W;
    wr_nxt    = state_nxt == WRITE;
    done_nxt  = state_nxt == DONE;
    addr_nxt  = state_nxt == FETCH_X ? X_BASE + 16'(idx_nxt) :
                state_nxt == FETCH_W ? W_BASE + 16'(idx_nxt) :
                state_nxt == WRITE   ? Y_ADDR : 16'h0000;
    wdata_nxt = state_nxt == WRITE ? wval : 16'h0000;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      x          <= '0;
      acc        <= '0;
      prev_start <= 1'b0;
      oACC_done  <= 1'b0;
      oMemReq    <= 1'b0;
      oMemRead   <= 1'b0;
      oMemWrite  <= 1'b0;
      oMemAddr   <= '0;
      oMemWData  <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      x          <= x_nxt;
      acc        <= acc_nxt;
      prev_start <= iACC_start;
      oACC_done  <= done_nxt;
      oMemReq    <= req_nxt;
      oMemRead   <= rd_nxt;
      oMemWrite  <= wr_nxt;
      oMemAddr   <= addr_nxt;
      oMemWData  <= wdata_nxt;
    end
  end
endmodule

// File: tb/tb_nn_accel.sv
// tb_nn_accel: directed checks of nn_accel with N_IN=1 and N_IN=4 instances sharing one memory model.
module tb_nn_accel;
  logic clk = 1'b0;
  logic rst_n;
  logic en1, st1, en4, st4;
  logic done1, req1, rd1, wr1, done4, req4, rd4, wr4;
  logic [15:0] addr1, data1, wdata1, addr4, data4, wdata4;
  logic [15:0] mem [256];
  logic [15:0] rd_log [128];
  int rd_cnt4 = 0, wr_cnt4 = 0;
  int checks = 0, errors = 0;
  int rc0, wc0;
  logic [15:0] relu_exp;
  always #5 clk = ~clk;
  nn_accel #(.N_IN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .iACC_en(en1), .iACC_start(st1), .oACC_done(done1),
    .oMemReq(req1), .oMemAddr(addr1), .oMemRead(rd1), .iMemData(data1),
    .oMemWrite(wr1), .oMemWData(wdata1)
  );
  nn_accel #(.N_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .iACC_en(en4), .iACC_start(st4), .oACC_done(done4),
    .oMemReq(req4), .oMemAddr(addr4), .oMemRead(rd4), .iMemData(data4),
    .oMemWrite(wr4), .oMemWData(wdata4)
  );
  always @(posedge clk) begin
    data1 <= rd1 ? mem[addr1[7:0]] : 16'hDEAD;
    data4 <= rd4 ? mem[addr4[7:0]] : 16'hDEAD;
    if (rd4) begin
      if (rd_cnt4 < 128) rd_log[rd_cnt4] <= addr4;
      rd_cnt4 <= rd_cnt4 + 1;
    end
    if (wr4) wr_cnt4 <= wr_cnt4 + 1;
  end
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    {en1, st1, en4, st4} = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    tick();
    tick();
    check("reset_u1", {done1, req1, rd1, wr1, addr1, wdata1}, 36'h0);
    check("reset_u4", {done4, req4, rd4, wr4, addr4, wdata4}, 36'h0);
    rst_n = 1'b1;
    tick();
    // N_IN=1 basic product
    mem[8'h40] = 16'h0200;
    mem[8'h80] = 16'h0180;
    en1 = 1'b1;
    st1 = 1'b1;
    tick();
    check("t1_fetch_x", {req1, rd1, addr1}, {2'b11, 16'h0040});
    tick();
    check("t1_fetch_w", {req1, rd1, addr1}, {2'b11, 16'h0080});
    tick();
    check("t1_mac", {req1, rd1, wr1, addr1}, {3'b100, 16'h0000});
    tick();
    check("t1_write", {done1, wr1, addr1, wdata1}, {2'b01, 16'h00C0, 16'h0300});
    tick();
    check("t1_done_e4", {done1, req1, wr1, addr1, wdata1}, {3'b100, 32'h0});
    st1 = 1'b0;
    repeat (3) tick();
    check("t1_done_held", done1, 1'b1);
    // negative result, optionally clamped
    mem[8'h40] = 16'h0100;
    mem[8'h80] = 16'hFF00;
`ifdef NN_ACCEL_RELU_EN
    relu_exp = 16'h0000;
`else
    relu_exp = 16'hFF00;
`endif
    st1 = 1'b1;
    tick();
    check("t3_restart_clears_done", {done1, rd1}, 2'b01);
    repeat (3) tick();
    check("t3_write", {wr1, addr1, wdata1}, {1'b1, 16'h00C0, relu_exp});
    tick();
    check("t3_done", done1, 1'b1);
    st1 = 1'b0;
    // N_IN=4 saturation and read ordering
    for (int i = 0; i < 4; i++) begin
      mem[8'h40 + i] = 16'h7FFF;
      mem[8'h80 + i] = 16'h7FFF;
    end
    rc0 = rd_cnt4;
    en4 = 1'b1;
    st4 = 1'b1;
    tick();
    repeat (12) tick();
    check("t2_write_sat", {done4, wr4, addr4, wdata4}, {2'b01, 16'h00C0, 16'h7FFF});
    tick();
    check("t2_done_e13", {done4, wr4}, 2'b10);
    check("t2_read_count", rd_cnt4 - rc0, 8);
    for (int j = 0; j < 8; j++)
      check($sformatf("t2_read_addr%0d", j), rd_log[rc0 + j],
            (j % 2 == 0) ? 16'h0040 + 16'(j / 2) : 16'h0080 + 16'(j / 2));
    // abort in MAC of element 1
    for (int i = 0; i < 4; i++) begin
      mem[8'h40 + i] = 16'(256 * (i + 1));
      mem[8'h80 + i] = 16'h0100;
    end
    st4 = 1'b0;
    tick();
    wc0 = wr_cnt4;
    st4 = 1'b1;
    tick();
    repeat (5) tick();
    check("t4_in_mac", {req4, rd4, wr4}, 3'b100);
    en4 = 1'b0;
    tick();
    check("t4_aborted", {done4, req4, rd4, wr4, addr4, wdata4}, 36'h0);
    repeat (5) tick();
    check("t4_no_write", wr_cnt4 - wc0, 0);
    check("t4_done_low", done4, 1'b0);
    st4 = 1'b0;
    en4 = 1'b1;
    tick();
    st4 = 1'b1;
    tick();
    repeat (12) tick();
    check("t4_rerun_write", {wr4, addr4, wdata4}, {1'b1, 16'h00C0, 16'h0A00});
    tick();
    check("t4_rerun_done", done4, 1'b1);
    check("t4_one_write", wr_cnt4 - wc0, 1);
    // held start must not retrigger
    rc0 = rd_cnt4;
    repeat (20) tick();
    check("t5_no_reads", rd_cnt4 - rc0, 0);
    check("t5_done_held", done4, 1'b1);
    st4 = 1'b0;
    tick();
    st4 = 1'b1;
    tick();
    check("t5_restart", {done4, rd4, addr4}, {2'b01, 16'h0040});
    repeat (12) tick();
    check("t5_write", {wr4, wdata4}, {1'b1, 16'h0A00});
    tick();
    check("t5_done", done4, 1'b1);
    // asynchronous reset during FETCH_W
    st4 = 1'b0;
    tick();
    st4 = 1'b1;
    tick();
    tick();
    check("t6_fetch_w", {rd4, addr4}, {1'b1, 16'h0080});
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_u4", {done4, req4, rd4, wr4, addr4, wdata4}, 36'h0);
    check("t6_async_u1", {done1, req1, rd1, wr1, addr1, wdata1}, 36'h0);
    st4 = 1'b0;
    tick();
    rst_n = 1'b1;
    rc0 = rd_cnt4;
    repeat (5) tick();
    check("t6_stays_idle", {done4, req4, rd4}, 3'b000);
    check("t6_no_reads", rd_cnt4 - rc0, 0);
    st4 = 1'b1;
    tick();
    check("t6_start_edge", {rd4, addr4}, {1'b1, 16'h0040});
    repeat (12) tick();
    check("t6_write", {wr4, wdata4}, {1'b1, 16'h0A00});
    tick();
    check("t6_done", done4, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nn_accel.md
# nn_accel

Neuron accelerator that answers the CPU's accelerator handshake. The CPU drives enable and start from status-register bits and samples done back into the status register. On each start request, the block streams an input vector and a weight vector from shared data memory and computes a fixed-point dot product. It writes the saturated result back to memory and raises done.

## Interface
Parameters:
- N_IN, 16, vector length; legal range 1..256
- X_BASE, 16'h0040, address of x[0]
- W_BASE, 16'h0080, address of w[0]
- Y_ADDR, 16'h00C0, result address
- FRAC, 8, fractional bits of the Q format used for x, w and y

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  reset; asynchronous, active-low
- iACC_en  input  1  accelerator enable (CPU status bit 3)
- iACC_start  input  1  start request (CPU status bit 4)
- oACC_done  output  1  operation complete (to CPU status bit 2)
- oMemReq  output  1  high while the block owns the data-memory port
- oMemAddr  output  16  memory address
- oMemRead  output  1  read strobe; data is returned on iMemData one cycle later
- iMemData  input  16  read data
- oMemWrite  output  1  write strobe
- oMemWData  output  16  write data

## Operation
- Start event: on a posedge where iACC_en=1, iACC_start=1, and the registered previous start is 0. This is level-to-edge detection; a held start never retriggers.
- States:
  - IDLE: waits for a start event, then goes to FETCH_X.
  - FETCH_X: oMemRead=1, oMemAddr=X_BASE+i. Goes to FETCH_W.
  - FETCH_W: captures iMemData into x. oMemRead=1, oMemAddr=W_BASE+i. Goes to MAC.
  - MAC: captures w and adds x*w to the accumulator. If i==N_IN-1, goes to WRITE; otherwise i increments and the FSM goes to FETCH_X.
  - WRITE: oMemWrite=1, oMemAddr=Y_ADDR, oMemWData=result. Goes to DONE.
  - DONE: oACC_done=1. Stays here until a start event (the FSM then clears done and restarts at FETCH_X) or until iACC_en=0 (the FSM goes to IDLE).
- The start event clears the accumulator and i.
- oMemReq=1 in FETCH_X, FETCH_W, MAC and WRITE; 0 otherwise.
- oMemAddr, oMemWData, oMemRead and oMemWrite are 0 whenever they are not driven as above.
- Arithmetic:
  - x and w are 16-bit signed; each product is 32-bit signed.
  - The accumulator is 40-bit signed, so it cannot overflow for N_IN ≤ 256.
  - result = accumulator arithmetic-shifted right by FRAC, saturated to [16'h8000, 16'h7FFF].
- Abort: iACC_en=0 in any non-IDLE state sends the FSM to IDLE on the next posedge. No write is issued, done stays 0, and all memory outputs drop.
- A start event while the FSM is in FETCH_X..WRITE is ignored.
- Addresses wrap modulo 2^16.

## Timing
- Reset: FSM goes to IDLE. oACC_done, oMemReq, oMemRead, oMemWrite, oMemAddr and oMemWData are all 0. Accumulator, i and the previous-start register are cleared. All of this takes effect immediately, including mid-operation.
- Let E0 be the posedge that detects the start event.
- Element k is fetched and accumulated in the cycles following edges E(3k) through E(3k+2).
- WRITE is the state in the cycle after edge E(3·N_IN).
- oACC_done rises at edge E(3·N_IN+1). Total latency is 3·N_IN+1 cycles.
- Outputs are registered and glitch-free. Done is a level, not a pulse.

## Configuration
- NN_ACCEL_RELU_EN defined: a negative saturated result is written as 16'h0000 (ReLU).
- NN_ACCEL_RELU_EN undefined: the signed saturated result is written unchanged.
- Latency is identical either way.

## Test plan
- N_IN=1, x[0]=16'h0200, w[0]=16'h0180 → one write of 16'h0300 to 16'h00C0; oACC_done high at E4 and held.
- N_IN=4, all x and w = 16'h7FFF → result saturates to 16'h7FFF; done at E13; exactly 8 reads, in address order 40,80,41,81,…
- N_IN=1, x=16'h0100, w=16'hFF00 → writes 16'hFF00 without the macro, 16'h0000 with NN_ACCEL_RELU_EN.
- N_IN=4, drop iACC_en in the MAC state of element 1 → IDLE next cycle, no write, done 0. Re-enable and issue a fresh start edge → a full run completes correctly.
- After done, hold iACC_start=1 for 20 cycles → no new reads. Then drive start 0 for one cycle, then 1 → done drops at that edge and a new run begins.
- Assert rst_n=0 during FETCH_W → every output is 0 asynchronously. After release, the block stays IDLE until a start edge.
